scsp_timers: RTL and testbench
==============================

# scsp_timers

Sound-processor timer unit implementing the three 8-bit interval timers A/B/C (control registers at 100418/10041A/10041C). Each timer counts sample ticks through a per-timer power-of-two prescaler and raises a one-cycle overflow pulse. The register bus interface feeds this block. Its pulses feed the interrupt controller, which sets pending bits 6/7/8 of SCIPD/MCIPD.

## Interface
Parameters:
- PRESC_W, 7, prescaler counter width. It must cover the maximum divide of 2^7 = 128 samples.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset. Asynchronous, active-high.
- CE  in  1  clock enable. All state advances only when CE=1.
- SAMPLE_CE  in  1  one-cycle pulse per output sample (44.1 kHz). Qualified by CE.
- TA_WR, TB_WR, TC_WR  in  1 each  register write strobes for timers A/B/C. Qualified by CE.
- BE  in  2  byte enables.
  - BE[1] writes the xCTL field, WDATA[10:8].
  - BE[0] writes the TIMx field, WDATA[7:0].
- WDATA  in  16  write data in CR8 layout: bits [15:11] unused, [10:8] CTL, [7:0] TIM.
- TA_RD, TB_RD, TC_RD  out  16 each  readback values: {5'b0, CTL, TIM}.
- IRQ_A, IRQ_B, IRQ_C  out  1 each  overflow pulses, high for exactly one CLK cycle.

## Operation
- State per timer x:
  - CTLx[2:0]: prescale select.
  - TIMx[7:0]: up-counter.
  - PRx[PRESC_W-1:0]: prescaler.
- Prescaler:
  - On each SAMPLE_CE, PRx increments.
  - A timer tick occurs when (PRx & ((1<<CTLx)-1)) == (1<<CTLx)-1. PRx then keeps incrementing, wrapping at 2^PRESC_W.
  - CTLx=0 ticks every sample. CTLx=7 ticks every 128 samples.
- Counter: on a tick, TIMx <= TIMx + 1, modulo 256.
- Overflow: when TIMx=FF and a tick occurs, TIMx wraps to 00 and IRQ_x pulses. The period from load value L is (256-L)·2^CTL samples.
- Write with TAx_WR and CE, where x is A/B/C:
  - BE[0]=1: TIMx <= WDATA[7:0] and PRx <= 0.
  - BE[1]=1: CTLx <= WDATA[10:8]. PRx is not cleared by a CTL-only write.
  - BE=2'b00: no effect.
- Simultaneous write and tick on the same timer:
  - With BE[0]=1, the write wins. No increment and no IRQ occur in that cycle, even if the old TIMx was FF.
  - With BE[0]=0 (CTL-only), the tick is evaluated with the old CTLx and the new CTLx takes effect from the next cycle.
- The three timers are fully independent. Simultaneous overflows assert all affected IRQ outputs in the same cycle.
- IRQ pulses are not latched here. Pending and clear handling belongs to the interrupt controller.

## Timing
- Reset values, asynchronous on RST=1:
  - TIMx=00, CTLx=0, PRx=0.
  - IRQ_x=0, TA/TB/TC_RD=0000.
  - Release is synchronous to CLK. The first SAMPLE_CE after release increments PRx from 0.
- RST asserted mid-count: all state returns to reset values immediately and any IRQ pulse in progress is cut off.
- Write latency: a register written in cycle n reads back in TA/TB/TC_RD from cycle n+1.
- Tick latency: with SAMPLE_CE in cycle n producing a tick, TIMx updates and IRQ_x (if overflow) is high in cycle n+1 only. It is registered, so it is high for exactly one CLK.
- With CE=0 nothing changes. IRQ_x still drops after one CLK and is never stretched by CE=0.
- SAMPLE_CE arriving on consecutive CE cycles is legal. Each one is counted.

## Test plan
- Reset:
  - Stimulus: assert RST mid-count with TIMA=0x80, CTLA=3.
  - Required response: all RD=0000 and IRQ=0 asynchronously. After release, 256 SAMPLE_CE pulses produce exactly one IRQ_A.
- Basic overflow:
  - Stimulus: write TA, BE=11, WDATA=0x00FE, then issue SAMPLE_CE pulses.
  - Required response: TIMA=FF after the 1st pulse. IRQ_A pulses one cycle after the 2nd pulse and TIMA=00. No other IRQ fires.
- Prescaler:
  - Stimulus: write TB, WDATA=0x03F0 (CTL=3, TIM=F0), then 128 SAMPLE_CE pulses.
  - Required response: TIMB increments once every 8 samples. IRQ_B fires exactly once, on the 128th pulse.
  - Stimulus: repeat with CTL=7, TIM=FF.
  - Required response: IRQ_B fires on the 128th pulse.
- Write/tick collision:
  - Stimulus: TIMC=FF, CTL=0. Write TC with BE=01, WDATA=0x0010 in the same cycle as SAMPLE_CE.
  - Required response: no IRQ_C and TIMC=10. The next SAMPLE_CE gives TIMC=11.
- CTL-only write:
  - Stimulus: CTLA=0, 5 samples counted, then write BE=10, WDATA=0x0200.
  - Required response: TIMA unchanged and PRA not cleared. Ticks then occur when PRA[1:0]==3.
- Independence and CE:
  - Stimulus: A, B and C all loaded with FF at CTL=0. One SAMPLE_CE arrives with CE=1, then CE is held 0 for 10 cycles.
  - Required response: IRQ_A/B/C all high in the same single cycle. All outputs are frozen while CE=0.

Source files
------------

// File: rtl/scsp_timers.sv
// scsp_timers: three independent 8-bit sample-tick interval timers with power-of-two prescalers and one-cycle overflow pulses
module scsp_timers #(
  parameter int PRESC_W = 7
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  input  logic        SAMPLE_CE,
  input  logic        TA_WR,
  input  logic        TB_WR,
  input  logic        TC_WR,
  input  logic [1:0]  BE,
  input  logic [15:0] WDATA,
  output logic [15:0] TA_RD,
  output logic [15:0] TB_RD,
  output logic [15:0] TC_RD,
  output logic        IRQ_A,
  output logic        IRQ_B,
  output logic        IRQ_C
);
  logic [2:0]  wr;
  logic [2:0]  irq;
  logic [15:0] rd [3];
  assign wr = {TC_WR, TB_WR, TA_WR};
  for (genvar i = 0; i < 3; i++) begin : g_t
    logic [2:0]         ctl;
    logic [7:0]         tim;
    logic [PRESC_W-1:0] pr;
    logic [PRESC_W-1:0] mask;
    logic               samp;
    logic               ld;
    logic               tick;
    logic               q;
    assign mask = PRESC_W'((32'd1 << ctl) - 32'd1);
    assign samp = CE & SAMPLE_CE;
    assign ld   = CE & wr[i] & BE[0];
    // tick is judged on the pre-increment prescaler and the current (old) CTL
    assign tick = samp & ((pr & mask) == mask);
    always_ff @(posedge CLK or posedge RST)
      if (RST) begin
        ctl <= '0;
        tim <= '0;
        pr  <= '0;
        q   <= 1'b0;
      end else begin
        q <= tick & ~ld & (tim == 8'hFF);
        if (ld) begin
          tim <= WDATA[7:0];
          pr  <= '0;
        end else begin
          if (tick) tim <= tim + 8'd1;
          if (samp) pr <= pr + 1'b1;
        end
        if (CE & wr[i] & BE[1]) ctl <= WDATA[10:8];
      end
    assign irq[i] = q;
    assign rd[i]  = {5'b0, ctl, tim};
  end
  assign TA_RD = rd[0];
  assign TB_RD = rd[1];
  assign TC_RD = rd[2];
  assign IRQ_A = irq[0];
  assign IRQ_B = irq[1];
  assign IRQ_C = irq[2];
endmodule

// File: tb/tb_scsp_timers.sv
// tb_scsp_timers: scoreboard bench; driver pushes model predictions, monitor pops and compares each cycle
module tb_scsp_timers;
  logic        CLK = 0, RST = 1, CE = 0, SAMPLE_CE = 0;
  logic        TA_WR = 0, TB_WR = 0, TC_WR = 0;
  logic [1:0]  BE = 0;
  logic [15:0] WDATA = 0;
  logic [15:0] TA_RD, TB_RD, TC_RD;
  logic        IRQ_A, IRQ_B, IRQ_C;
  int vectors = 0, miscompares = 0;
  logic [50:0] exp_q[$];
  int m_tim[3], m_ctl[3], m_pr[3];

  scsp_timers #(.PRESC_W(7)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .SAMPLE_CE(SAMPLE_CE),
    .TA_WR(TA_WR), .TB_WR(TB_WR), .TC_WR(TC_WR), .BE(BE), .WDATA(WDATA),
    .TA_RD(TA_RD), .TB_RD(TB_RD), .TC_RD(TC_RD),
    .IRQ_A(IRQ_A), .IRQ_B(IRQ_B), .IRQ_C(IRQ_C)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  initial forever begin
    logic [50:0] e;
    @(posedge CLK);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("irq", {13'b0, IRQ_C, IRQ_B, IRQ_A}, {13'b0, e[50:48]});
      check("ta_rd", TA_RD, e[47:32]);
      check("tb_rd", TB_RD, e[31:16]);
      check("tc_rd", TC_RD, e[15:0]);
    end
  end

  // Model: a timer ticks on every 2^CTL-th sample counted since the last TIM load
  task automatic step(input logic r, input logic c, input logic s, input logic [2:0] w,
                      input logic [1:0] b, input logic [15:0] d);
    logic [2:0] irq;
    int per;
    bit tick;
    irq = 3'b0;
    @(negedge CLK);
    RST = r; CE = c; SAMPLE_CE = s; {TC_WR, TB_WR, TA_WR} = w; BE = b; WDATA = d;
    if (r) begin
      for (int t = 0; t < 3; t++) begin m_tim[t] = 0; m_ctl[t] = 0; m_pr[t] = 0; end
      exp_q.push_back('0);
      #1;
      check("async_rst_rd", TA_RD | TB_RD | TC_RD, 16'h0);
      check("async_rst_irq", {13'b0, IRQ_C, IRQ_B, IRQ_A}, 16'h0);
    end else begin
      for (int t = 0; t < 3; t++) begin
        per  = 1 << m_ctl[t];
        tick = c && s && (m_pr[t] % per == per - 1);
        if (c && w[t] && b[0]) begin
          m_tim[t] = d[7:0];
          m_pr[t]  = 0;
        end else begin
          if (tick) begin
            irq[t]   = (m_tim[t] == 255);
            m_tim[t] = (m_tim[t] + 1) % 256;
          end
          if (c && s) m_pr[t] = (m_pr[t] + 1) % 128;
        end
        if (c && w[t] && b[1]) m_ctl[t] = d[10:8];
      end
      exp_q.push_back({irq, 5'b0, 3'(m_ctl[0]), 8'(m_tim[0]),
                       5'b0, 3'(m_ctl[1]), 8'(m_tim[1]),
                       5'b0, 3'(m_ctl[2]), 8'(m_tim[2])});
    end
  endtask

  task automatic write(input logic [2:0] w, input logic [1:0] b, input logic [15:0] d);
    step(0, 1, 0, w, b, d);
  endtask

  task automatic samples(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 1, 3'b0, 2'b0, 16'h0);
  endtask

  initial begin
    step(1, 1, 0, 3'b0, 2'b0, 16'h0);
    step(0, 1, 0, 3'b0, 2'b0, 16'h0);
    write(3'b001, 2'b11, 16'h0380);
    samples(13);
    step(1, 1, 1, 3'b0, 2'b0, 16'h0);
    step(1, 1, 1, 3'b0, 2'b0, 16'h0);
    samples(258);
    write(3'b001, 2'b11, 16'h00FE);
    samples(3);
    write(3'b010, 2'b11, 16'h03F0);
    samples(130);
    write(3'b010, 2'b11, 16'h07FF);
    samples(130);
    write(3'b100, 2'b11, 16'h00FF);
    step(0, 1, 1, 3'b100, 2'b01, 16'h0010);
    samples(2);
    write(3'b001, 2'b11, 16'h0000);
    samples(5);
    write(3'b001, 2'b10, 16'h0200);
    samples(12);
    write(3'b111, 2'b11, 16'h00FF);
    samples(1);
    for (int i = 0; i < 10; i++)
      step(0, 0, 1'($urandom), 3'($urandom), 2'($urandom), 16'($urandom));
    samples(2);
    for (int i = 0; i < 3000; i++) begin
      logic r;
      logic [2:0] w;
      r = ($urandom_range(0, 599) == 0);
      w = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b0;
      step(r, $urandom_range(0, 3) != 0, 1'($urandom), w, 2'($urandom),
           {5'($urandom), 3'($urandom_range(0, 2)), 8'($urandom_range(8'hF0, 8'hFF))});
    end
    step(0, 1, 0, 3'b0, 2'b0, 16'h0);
    @(posedge CLK);
    #3;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
